// File: rtl/fp_mult_pkg.sv
// Shared types and constant generators for the pipelined IEEE-754 multiplier.
// Rounding mode is selected by FP_MULT_RNE_EN (defined: round-to-nearest-even, undefined: truncate).
package fp_mult_pkg;

    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

    function automatic int fpBias(input int expW);
        return (1 << (expW - 1)) - 1;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set, rest clear.
    function automatic logic [63:0] fpQnan(input int expW, input int manW);
        logic [63:0] ones;
        ones = (64'd1 << (expW + 1)) - 64'd1;
        return ones << (manW - 1);
    endfunction

endpackage

// File: rtl/fp_mult_pipe_round_pack.sv
// Final-stage normalize, round, pack and flag generation for the FP multiplier.
// FP_MULT_RNE_EN selects round-to-nearest-even; otherwise the product is truncated.
module fp_round_pack
    import fp_mult_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int W     = 1 + EXP_W + MAN_W
) (
    input  logic                    i_sign,
    input  fp_class_e               i_cls,
    input  logic signed [EXP_W+1:0] i_expSum,
    input  logic [2*MAN_W+1:0]      i_prod,
    output logic [W-1:0]            o_result,
    output logic                    o_overflow,
    output logic                    o_underflow,
    output logic                    o_invalid
);
    localparam int EW2 = EXP_W + 2;
    localparam int PW  = 2 * MAN_W + 2;
    localparam logic signed [EW2-1:0] EXP_MAX  = EW2'((1 << EXP_W) - 1);
    localparam logic signed [EW2-1:0] EXP_ZERO = '0;
    localparam logic signed [EW2-1:0] EXP_ONE  = EW2'(1);
    localparam logic [63:0]           QNAN_64  = fpQnan(EXP_W, MAN_W);
    localparam logic [W-1:0]          QNAN     = QNAN_64[W-1:0];

    logic [MAN_W-1:0]       w_mant;
    logic                   w_guard;
    logic                   w_sticky;
    logic                   w_roundUp;
    logic [MAN_W:0]         w_mantR;
    logic signed [EW2-1:0]  w_expN;
    logic signed [EW2-1:0]  w_expF;

    // Product of two [1,2) significands lies in [1,4); bring it back to [1,2).
    always_comb begin
        if (i_prod[PW-1]) begin
            w_mant   = i_prod[PW-2 -: MAN_W];
            w_guard  = i_prod[MAN_W];
            w_sticky = |i_prod[MAN_W-1:0];
            w_expN   = i_expSum + EXP_ONE;
        end else begin
            w_mant   = i_prod[PW-3 -: MAN_W];
            w_guard  = i_prod[MAN_W-1];
            w_sticky = |i_prod[MAN_W-2:0];
            w_expN   = i_expSum;
        end
    end

`ifdef FP_MULT_RNE_EN
    assign w_roundUp = w_guard & (w_sticky | w_mant[0]);
`else
    logic w_unusedRoundBits;
    assign w_unusedRoundBits = w_guard | w_sticky;
    assign w_roundUp = 1'b0;
`endif

    assign w_mantR = {1'b0, w_mant} + {{MAN_W{1'b0}}, w_roundUp};
    assign w_expF  = w_mantR[MAN_W] ? (w_expN + EXP_ONE) : w_expN;

    always_comb begin
        o_result    = '0;
        o_overflow  = 1'b0;
        o_underflow = 1'b0;
        o_invalid   = 1'b0;
        case (i_cls)
            NAN: begin
                o_result  = QNAN;
                o_invalid = 1'b1;
            end
            INF:  o_result = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ZERO: o_result = {i_sign, {(W-1){1'b0}}};
            default: begin
                if (w_expF >= EXP_MAX) begin
                    o_result   = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    o_overflow = 1'b1;
                end else if (w_expF <= EXP_ZERO) begin
                    o_result    = {i_sign, {(W-1){1'b0}}};
                    o_underflow = 1'b1;
                end else begin
                    o_result = {i_sign, w_expF[EXP_W-1:0], w_mantR[MAN_W-1:0]};
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined IEEE-754 multiplier with valid/ready on both sides.
// Rounding mode is selected by FP_MULT_RNE_EN (defined: RNE, undefined: truncation).
module fp_mult_pipe
    import fp_mult_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         overflow,
    output logic         underflow,
    output logic         invalid
);
    localparam int EW2 = EXP_W + 2;
    localparam int SW  = MAN_W + 1;
    localparam logic signed [EW2-1:0] BIAS = EW2'(fpBias(EXP_W));

    typedef struct packed {
        logic                  sign;
        fp_class_e             cls;
        logic signed [EW2-1:0] expSum;
        logic [SW-1:0]         sigA;
        logic [SW-1:0]         sigB;
    } s12_t;

    typedef struct packed {
        logic                  sign;
        fp_class_e             cls;
        logic signed [EW2-1:0] expSum;
        logic [2*SW-1:0]       prod;
    } s23_t;

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        if (e == '0) return ZERO;
        if (e != '1) return NORM;
        if (f == '0) return INF;
        return NAN;
    endfunction

    fp_class_e    w_clsA, w_clsB;
    s12_t         w_s1, r_s1;
    s23_t         w_s2, r_s2;
    logic         r_v1, r_v2, r_v3;
    logic         w_load1, w_load2, w_load3;
    logic [W-1:0] w_result, r_result;
    logic         w_overflow, w_underflow, w_invalid;
    logic         r_overflow, r_underflow, r_invalid;

    // A stage may load when empty or when its successor is taking its entry.
    assign w_load3  = !r_v3 || out_ready;
    assign w_load2  = !r_v2 || w_load3;
    assign w_load1  = !r_v1 || w_load2;
    assign in_ready = w_load1;

    // Operand pair collapses to a single class, ordered by special-case precedence.
    always_comb begin
        w_clsA      = classify(a[W-2 -: EXP_W], a[MAN_W-1:0]);
        w_clsB      = classify(b[W-2 -: EXP_W], b[MAN_W-1:0]);
        w_s1        = '0;
        w_s1.sign   = a[W-1] ^ b[W-1];
        w_s1.expSum = $signed({2'b00, a[W-2 -: EXP_W]}) + $signed({2'b00, b[W-2 -: EXP_W]}) - BIAS;
        w_s1.sigA   = {1'b1, a[MAN_W-1:0]};
        w_s1.sigB   = {1'b1, b[MAN_W-1:0]};
        if (w_clsA == NAN || w_clsB == NAN ||
            (w_clsA == INF && w_clsB == ZERO) || (w_clsA == ZERO && w_clsB == INF))
            w_s1.cls = NAN;
        else if (w_clsA == INF || w_clsB == INF)
            w_s1.cls = INF;
        else if (w_clsA == ZERO || w_clsB == ZERO)
            w_s1.cls = ZERO;
        else
            w_s1.cls = NORM;
    end

    always_comb begin
        w_s2        = '0;
        w_s2.sign   = r_s1.sign;
        w_s2.cls    = r_s1.cls;
        w_s2.expSum = r_s1.expSum;
        w_s2.prod   = (2*SW)'(r_s1.sigA) * (2*SW)'(r_s1.sigB);
    end

    fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W), .W(W)) u_roundPack (
        .i_sign      (r_s2.sign),
        .i_cls       (r_s2.cls),
        .i_expSum    (r_s2.expSum),
        .i_prod      (r_s2.prod),
        .o_result    (w_result),
        .o_overflow  (w_overflow),
        .o_underflow (w_underflow),
        .o_invalid   (w_invalid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_s1 <= '0;
        end else if (w_load1) begin
            r_v1 <= in_valid;
            if (in_valid) r_s1 <= w_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2 <= 1'b0;
            r_s2 <= '0;
        end else if (w_load2) begin
            r_v2 <= r_v1;
            if (r_v1) r_s2 <= w_s2;
        end
    end

    // Output register holds its contents while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3        <= 1'b0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_invalid   <= 1'b0;
        end else if (w_load3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_result    <= w_result;
                r_overflow  <= w_overflow;
                r_underflow <= w_underflow;
                r_invalid   <= w_invalid;
            end
        end
    end

    assign out_valid = r_v3;
    assign result    = r_result;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign invalid   = r_invalid;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Self-checking bench for fp_mult_pipe: directed spec vectors plus randomized traffic
// against an integer-arithmetic reference model; rounding expectations follow FP_MULT_RNE_EN.
module tb_fp_mult_pipe;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inv;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic        overflow, underflow, invalid;

    logic        hInValid, hInReady, hOutValid, hOutReady;
    logic [15:0] ha, hb, hResult;
    logic        hOverflow, hUnderflow, hInvalid;

    int passCount  = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    fp_mult_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .underflow(underflow), .invalid(invalid)
    );

    fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) halfDut (
        .clk(clk), .rst_n(rst_n), .in_valid(hInValid), .in_ready(hInReady),
        .a(ha), .b(hb), .out_valid(hOutValid), .out_ready(hOutReady),
        .result(hResult), .overflow(hOverflow), .underflow(hUnderflow), .invalid(hInvalid)
    );

    // Reference: value = sigA*sigB * 2^(ea+eb-2*bias-46), rounded by comparing the discarded remainder to half an ulp.
    function automatic exp_t refMul(input logic [31:0] x, input logic [31:0] y);
        exp_t r;
        logic [7:0] ex, ey;
        logic xNan, yNan, xInf, yInf, xZero, yZero, s;
        longint unsigned p, q, rem, half, sx, sy;
        int e, sh;
        r  = '0;
        ex = x[30:23];
        ey = y[30:23];
        xNan  = (ex == 8'hFF) && (x[22:0] != 0);
        yNan  = (ey == 8'hFF) && (y[22:0] != 0);
        xInf  = (ex == 8'hFF) && (x[22:0] == 0);
        yInf  = (ey == 8'hFF) && (y[22:0] == 0);
        xZero = (ex == 8'h00);
        yZero = (ey == 8'h00);
        s = x[31] ^ y[31];
        if (xNan || yNan || (xInf && yZero) || (yInf && xZero)) begin
            r.res = 32'h7FC00000;
            r.inv = 1'b1;
            return r;
        end
        if (xInf || yInf) begin
            r.res = {s, 8'hFF, 23'd0};
            return r;
        end
        if (xZero || yZero) begin
            r.res = {s, 31'd0};
            return r;
        end
        sx = {41'd1, x[22:0]};
        sy = {41'd1, y[22:0]};
        p  = sx * sy;
        e  = int'(ex) + int'(ey) - 127;
        sh = 23;
        if (p >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
        end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
`ifdef FP_MULT_RNE_EN
        if (rem > half || (rem == half && q[0])) q = q + 1;
`else
        if (rem > half) q = q;
`endif
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) begin
            r.res = {s, 8'hFF, 23'd0};
            r.ovf = 1'b1;
        end else if (e <= 0) begin
            r.res = {s, 31'd0};
            r.unf = 1'b1;
        end else begin
            r.res = {s, e[7:0], q[22:0]};
        end
        return r;
    endfunction

    function automatic logic [31:0] randOperand();
        int mode;
        logic [31:0] v;
        mode = $urandom_range(0, 11);
        v = $urandom;
        case (mode)
            0: v = {v[31], 31'd0};
            1: v = {v[31], 8'hFF, 23'd0};
            2: v = {v[31], 8'hFF, v[22:1], 1'b1};
            3: v = v;
            4: v = {v[31], 8'h00, v[22:0]};
            default: begin
                v[30:23] = 8'($urandom_range(1, 254));
                if (mode > 7) v[30:23] = 8'($urandom_range(64, 190));
            end
        endcase
        return v;
    endfunction

    // One cycle: drive at the falling edge, then sample both handshakes just after.
    task automatic step(input logic inV, input logic [31:0] ia, input logic [31:0] ib, input logic outR,
                        output logic accepted, output logic delivered, output exp_t got);
        @(negedge clk);
        in_valid  = inV;
        a         = ia;
        b         = ib;
        out_ready = outR;
        #1;
        accepted  = inV && in_ready;
        delivered = out_valid && out_ready;
        got       = '{result, overflow, underflow, invalid};
    endtask

    task automatic runOne(input logic [31:0] ia, input logic [31:0] ib, output exp_t got, output int latency);
        logic acc, del;
        exp_t g;
        got = '0;
        latency = 0;
        step(1'b1, ia, ib, 1'b1, acc, del, g);
        for (int k = 1; k <= 10 && latency == 0; k++) begin
            step(1'b0, 32'd0, 32'd0, 1'b1, acc, del, g);
            if (del) begin
                latency = k;
                got = g;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        hInValid = 1'b0; hOutReady = 1'b0; ha = '0; hb = '0;
        repeat (3) @(negedge clk);
        checkCount++;
        if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        else passCount++;
        checkCount++;
        if (result !== 32'd0) $display("[TB] FAIL reset_result: got %h expected 00000000", result);
        else passCount++;
        checkCount++;
        if ({overflow, underflow, invalid} !== 3'b000)
            $display("[TB] FAIL reset_flags: got %b expected 000", {overflow, underflow, invalid});
        else passCount++;
        checkCount++;
        if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        else passCount++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] va[3] = '{32'h40000000, 32'hBF800000, 32'h40200000};
        logic [31:0] vb[3] = '{32'h3F800000, 32'h40000000, 32'h40600000};
        logic [31:0] ve[3] = '{32'h40000000, 32'hC0000000, 32'h410C0000};
        exp_t got;
        int lat;
        for (int i = 0; i < 3; i++) begin
            runOne(va[i], vb[i], got, lat);
            checkCount++;
            if (lat !== 3) $display("[TB] FAIL basic_latency[%0d]: got %0d expected 3", i, lat);
            else passCount++;
            checkCount++;
            if (got !== exp_t'({ve[i], 3'b000}))
                $display("[TB] FAIL basic_value[%0d]: got %h/%b expected %h/000", i, got.res, {got.ovf, got.unf, got.inv}, ve[i]);
            else passCount++;
        end
    endtask

    task automatic test_specials();
        logic [31:0] va[7] = '{32'h7F800000, 32'hFF800000, 32'h44FC7333, 32'h00000000,
                               32'h7F000000, 32'h00800000, 32'h3F800001};
        logic [31:0] vb[7] = '{32'h00000000, 32'hFF800000, 32'hFF800001, 32'h80000000,
                               32'h40000000, 32'h3F000000, 32'h3FC00000};
        exp_t ve[7];
        exp_t got;
        int lat;
        ve[0] = '{32'h7FC00000, 1'b0, 1'b0, 1'b1};
        ve[1] = '{32'h7F800000, 1'b0, 1'b0, 1'b0};
        ve[2] = '{32'h7FC00000, 1'b0, 1'b0, 1'b1};
        ve[3] = '{32'h80000000, 1'b0, 1'b0, 1'b0};
        ve[4] = '{32'h7F800000, 1'b1, 1'b0, 1'b0};
        ve[5] = '{32'h00000000, 1'b0, 1'b1, 1'b0};
`ifdef FP_MULT_RNE_EN
        ve[6] = '{32'h3FC00002, 1'b0, 1'b0, 1'b0};
`else
        ve[6] = '{32'h3FC00001, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 7; i++) begin
            runOne(va[i], vb[i], got, lat);
            checkCount++;
            if (lat == 0 || got !== ve[i])
                $display("[TB] FAIL special[%0d] %h*%h: got %h/%b (lat %0d) expected %h/%b", i, va[i], vb[i],
                         got.res, {got.ovf, got.unf, got.inv}, lat, ve[i].res, {ve[i].ovf, ve[i].unf, ve[i].inv});
            else passCount++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t expQ[$];
        exp_t got, e;
        logic acc, del;
        logic [31:0] x, y;
        int nAcc = 0, nDel = 0, firstCyc = -1, lastCyc = -1;
        for (int c = 0; c < 20; c++) begin
            x = randOperand();
            y = randOperand();
            step(nAcc < 5, x, y, 1'b1, acc, del, got);
            if (acc) begin
                expQ.push_back(refMul(x, y));
                nAcc++;
            end
            if (del) begin
                if (firstCyc < 0) firstCyc = c;
                lastCyc = c;
                nDel++;
                e = (expQ.size() > 0) ? expQ.pop_front() : '0;
                checkCount++;
                if (got !== e) $display("[TB] FAIL b2b_value: got %h/%b expected %h/%b", got.res,
                                        {got.ovf, got.unf, got.inv}, e.res, {e.ovf, e.unf, e.inv});
                else passCount++;
            end
        end
        checkCount++;
        if (nAcc !== 5) $display("[TB] FAIL b2b_accepts: got %0d expected 5 (one per cycle)", nAcc);
        else passCount++;
        checkCount++;
        if (nDel !== 5 || lastCyc - firstCyc !== 4)
            $display("[TB] FAIL b2b_stream: got %0d results over %0d cycles expected 5 over 5", nDel, lastCyc - firstCyc + 1);
        else passCount++;
    endtask

    task automatic test_backpressure();
        exp_t expQ[$];
        exp_t got, held, e;
        logic acc, del;
        logic [31:0] x, y;
        int nAcc = 0, nDel = 0;
        x = randOperand();
        y = randOperand();
        for (int c = 0; c < 6; c++) begin
            step(1'b1, x, y, 1'b0, acc, del, got);
            if (c == 3) held = got;
            if (acc) begin
                expQ.push_back(refMul(x, y));
                nAcc++;
                x = randOperand();
                y = randOperand();
            end
        end
        checkCount++;
        if (nAcc !== 3 || in_ready !== 1'b0)
            $display("[TB] FAIL bp_capacity: got %0d accepts in_ready %b expected 3 accepts in_ready 0", nAcc, in_ready);
        else passCount++;
        checkCount++;
        if (out_valid !== 1'b1 || got !== held)
            $display("[TB] FAIL bp_hold: got valid %b %h expected valid 1 %h", out_valid, got.res, held.res);
        else passCount++;
        for (int c = 0; c < 15; c++) begin
            step(nAcc < 5, x, y, 1'b1, acc, del, got);
            if (acc) begin
                expQ.push_back(refMul(x, y));
                nAcc++;
                x = randOperand();
                y = randOperand();
            end
            if (del) begin
                nDel++;
                e = (expQ.size() > 0) ? expQ.pop_front() : '0;
                checkCount++;
                if (got !== e) $display("[TB] FAIL bp_value: got %h expected %h", got.res, e.res);
                else passCount++;
            end
        end
        checkCount++;
        if (nDel !== 5) $display("[TB] FAIL bp_count: got %0d results expected 5", nDel);
        else passCount++;
    endtask

    task automatic test_random();
        exp_t expQ[$];
        exp_t got, e;
        logic acc, del;
        logic [31:0] x, y;
        for (int c = 0; c < 400; c++) begin
            x = randOperand();
            y = randOperand();
            step(c < 370 && ($urandom_range(0, 3) != 0), x, y, $urandom_range(0, 3) != 0, acc, del, got);
            if (acc) expQ.push_back(refMul(x, y));
            if (del) begin
                e = (expQ.size() > 0) ? expQ.pop_front() : '0;
                checkCount++;
                if (got !== e) $display("[TB] FAIL random_value: got %h/%b expected %h/%b", got.res,
                                        {got.ovf, got.unf, got.inv}, e.res, {e.ovf, e.unf, e.inv});
                else passCount++;
            end
        end
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 32'd0, 32'd0, 1'b1, acc, del, got);
            if (del) begin
                e = (expQ.size() > 0) ? expQ.pop_front() : '0;
                checkCount++;
                if (got !== e) $display("[TB] FAIL random_drain: got %h expected %h", got.res, e.res);
                else passCount++;
            end
        end
        checkCount++;
        if (expQ.size() !== 0) $display("[TB] FAIL random_lost: got %0d pending expected 0", expQ.size());
        else passCount++;
    endtask

    task automatic test_reset_midflight();
        exp_t got;
        logic acc, del;
        int nAcc = 0, stale = 0;
        for (int c = 0; c < 5 && nAcc < 3; c++) begin
            step(1'b1, 32'h40400000, 32'h40400000, 1'b0, acc, del, got);
            if (acc) nAcc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkCount++;
        if (out_valid !== 1'b0 || nAcc !== 3)
            $display("[TB] FAIL midreset_flush: got out_valid %b after %0d accepts expected 0 after 3", out_valid, nAcc);
        else passCount++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 32'd0, 32'd0, 1'b1, acc, del, got);
            if (out_valid) stale++;
        end
        checkCount++;
        if (stale !== 0) $display("[TB] FAIL midreset_stale: got %0d stale cycles expected 0", stale);
        else passCount++;
    endtask

    task automatic test_half();
        logic [15:0] va[2] = '{16'h4000, 16'h7BFF};
        logic [15:0] vb[2] = '{16'h3C00, 16'h4000};
        logic [18:0] ve[2] = '{{16'h4000, 3'b000}, {16'h7C00, 3'b100}};
        logic [18:0] got;
        bit seen;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            hInValid = 1'b1; ha = va[i]; hb = vb[i]; hOutReady = 1'b1;
            @(negedge clk);
            hInValid = 1'b0;
            seen = 1'b0;
            got = '0;
            for (int k = 0; k < 10 && !seen; k++) begin
                if (hOutValid) begin
                    seen = 1'b1;
                    got = {hResult, hOverflow, hUnderflow, hInvalid};
                end else @(negedge clk);
            end
            @(negedge clk);
            checkCount++;
            if (!seen || got !== ve[i])
                $display("[TB] FAIL half[%0d]: got %h/%b seen %b expected %h/%b", i, got[18:3], got[2:0], seen, ve[i][18:3], ve[i][2:0]);
            else passCount++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_specials();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midflight();
        test_half();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
- Parametrised, pipelined IEEE-754 binary multiplier; successor to the combinational single-precision `mult`.
- Generalised over exponent and mantissa width, so default is binary32 and binary16/binary64 come from parameters.
- 3-stage pipeline with valid/ready on both sides, full throughput; adds an invalid flag and RNE rounding.
- Sits between operand-issue logic and the FP result bus.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width (hidden bit excluded).
- W, 1+EXP_W+MAN_W, derived word width; must not be overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts the pair this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  W  packed product.
- overflow  out  1  result saturated to ±Inf; qualified by out_valid.
- underflow  out  1  nonzero product flushed to ±0; qualified by out_valid.
- invalid  out  1  NaN operand, or Inf×0; qualified by out_valid.

Behaviour:
- Reset (async assert, sync deassert by the system): all stage valids = 0; out_valid = 0; result = 0; all flags = 0; data registers cleared.
- Handshake:
  - Transfer occurs when valid && ready.
  - Stage k loads when its valid is 0, or stage k+1 loads this cycle. The last stage counts as "loading" when out_ready = 1.
  - in_ready = stage1 loads. A combinational path out_ready -> in_ready is permitted.
  - out_valid/result/flags hold stable while out_valid && !out_ready.
- Latency: 3 cycles from accept to out_valid with out_ready held 1. Throughput 1/cycle. Capacity 3 in flight.
- S1, classify and unpack:
  - Classes: ZERO (exp = 0, any fraction; subnormals flushed), INF, NAN, NORM.
  - sign = sa ^ sb.
  - exp_sum = ea + eb − BIAS, computed in EXP_W+2 signed bits, where BIAS = 2^(EXP_W−1) − 1.
- S2: significand product {1,fa} × {1,fb}, giving a 2·(MAN_W+1)-bit product.
- S3 (fp_round_pack):
  - Normalize: if product MSB = 1, shift right by 1 and exp+1.
  - Round to MAN_W bits (see Optional Feature). A rounding carry out renormalizes and adds exp+1.
  - Then: exp ≥ 2^EXP_W − 1 gives ±Inf with overflow = 1. exp ≤ 0 gives ±0 with underflow = 1.
- Special cases, precedence top-down:
  - Any NAN, or INF×ZERO: result = canonical qNaN (sign 0, exp all-ones, fraction MSB 1, rest 0); invalid = 1.
  - INF×any: ±Inf, no flags.
  - ZERO×any: ±0, no flags.
- At most one flag is asserted per result.
- Reset mid-operation: all in-flight entries are discarded and no output appears.

Optional Feature:
- Macro FP_MULT_RNE_EN.
- Defined: round-to-nearest-even using guard and sticky bits (sticky = OR of all lower product bits).
- Undefined: truncation (round toward zero), so no rounding carry occurs.
- Special-case, overflow and underflow rules are identical in both builds.

Decomposition:
- Package fp_mult_pkg holds:
  - enum fp_class_e {ZERO, NORM, INF, NAN};
  - function-based BIAS and qNaN constant generators parametrised by EXP_W/MAN_W;
  - packed structs for the S1->S2 and S2->S3 payloads (sign, class, exp_sum, significands/product).
- One sub-module, fp_round_pack: S3 combinational normalize, round and pack, plus flag generation.

Test Plan:
- a = 0x40000000, b = 0x3F800000 -> result 0x40000000 exactly 3 cycles later, no flags. Then -1×2 (0xBF800000 × 0x40000000) -> 0xC0000000. Then 2.5×3.5 (0x40200000 × 0x40600000) -> 0x410C0000.
- Streaming and backpressure: 5 back-to-back pairs with out_ready = 1 give one result per cycle, in order. With out_ready = 0, in_ready drops after 3 accepts, results hold stable, and none are lost or duplicated when out_ready returns.
- Specials:
  - 0x7F800000 × 0x00000000 -> 0x7FC00000, invalid = 1.
  - 0xFF800000 × 0xFF800000 -> 0x7F800000.
  - 0x44FC7333 × 0xFF800001 -> 0x7FC00000, invalid = 1.
  - 0x00000000 × 0x80000000 -> 0x80000000.
- Range limits:
  - 0x7F000000 × 0x40000000 -> 0x7F800000, overflow = 1.
  - 0x00800000 × 0x3F000000 -> 0x00000000, underflow = 1.
- Rounding: 0x3F800001 × 0x3FC00000 (tie case) -> 0x3FC00002 with FP_MULT_RNE_EN, 0x3FC00001 without.
- Reset and width:
  - rst_n pulsed low with 3 entries in flight -> out_valid = 0 immediately; after release no stale results appear.
  - Rerun the first scenario with EXP_W = 5, MAN_W = 10: 0x4000 × 0x3C00 -> 0x4000.
